// File: rtl/sar_search_4b.sv
// Successive-approximation search controller.
// Drives a probe into a greater-than comparator, reads gt back and binary-searches
// the hidden target one bit per cycle, MSB first. The result is returned on a
// val/rdy output stream.
module sar_search_4b #(
    parameter int unsigned nbits = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             istream_val,
    output logic             istream_rdy,
    output logic [nbits-1:0] probe,
    input  logic             gt,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] ostream_msg
);

    localparam int unsigned IdxW = (nbits > 1) ? $clog2(nbits) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(nbits - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [nbits-1:0] result_q, result_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [nbits-1:0] trial;

    // Bits below idx are always zero in result, so the OR never carries out of range.
    assign trial = result_q | (nbits'(1) << idx_q);

    // Result is driven at all times; it is only meaningful while ostream_val is high.
    assign ostream_msg = result_q;

    // Next-state and output decode; probe stays zero outside the search.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        idx_d       = idx_q;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        probe       = '0;
        case (state_q)
            StIdle: begin
                istream_rdy = 1'b1;
                if (istream_val) begin
                    result_d = '0;
                    idx_d    = IdxTop;
                    state_d  = StSearch;
                end
            end
            StSearch: begin
                probe = trial;
                // Keep the trial bit only when the probe does not overshoot the target.
                if (!gt) begin
                    result_d = trial;
                end
                if (idx_q == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StDone: begin
                ostream_val = 1'b1;
                if (ostream_rdy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset abandons any search in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_sar_search_4b.sv
// Self-checking bench for sar_search_4b: directed vector table, multi-cycle corner
// sequences (back-to-back, async reset mid-search) and randomised searches.
module tb_sar_search_4b;

    logic       clk;
    logic       reset;
    logic       istream_val;
    logic       istream_rdy;
    logic [3:0] probe;
    logic       gt;
    logic       ostream_val;
    logic       ostream_rdy;
    logic [3:0] ostream_msg;
    logic [3:0] target;

    int n_checks = 0;
    int n_fail   = 0;

    sar_search_4b #(.nbits(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .probe       (probe),
        .gt          (gt),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    // Behavioural GT comparator: in0 = probe, in1 = hidden target.
    assign gt = (probe > target);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] target;
        logic [3:0] p0, p1, p2, p3;
        logic [3:0] msg;
        int         stall;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic [3:0] t, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] c, input logic [3:0] d,
                           input logic [3:0] m, input int s);
        vecs[i].target = t;
        vecs[i].p0     = a;
        vecs[i].p1     = b;
        vecs[i].p2     = c;
        vecs[i].p3     = d;
        vecs[i].msg    = m;
        vecs[i].stall  = s;
    endtask

    // One complete search from IDLE; called at a negedge, returns at a negedge in IDLE.
    task automatic do_search(input logic [3:0] t, input logic [3:0] exp_p [4],
                             input logic [3:0] exp_msg, input int stall);
        check("idle_rdy", istream_rdy, 1'b1);
        check("idle_probe", probe, 4'd0);
        target      = t;
        istream_val = 1'b1;
        ostream_rdy = 1'b0;
        @(negedge clk);
        istream_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("probe%0d_t%0d", i, t), probe, exp_p[i]);
            check("search_rdy", istream_rdy, 1'b0);
            check("search_oval", ostream_val, 1'b0);
            @(negedge clk);
        end
        for (int k = 0; k <= stall; k++) begin
            check("done_val", ostream_val, 1'b1);
            check($sformatf("done_msg_t%0d", t), ostream_msg, exp_msg);
            check("done_irdy", istream_rdy, 1'b0);
            check("done_probe", probe, 4'd0);
            if (k == stall) ostream_rdy = 1'b1;
            @(negedge clk);
        end
        ostream_rdy = 1'b0;
        check("back_idle_rdy", istream_rdy, 1'b1);
        check("back_idle_oval", ostream_val, 1'b0);
    endtask

    logic [3:0] ep [4];
    logic [3:0] r, p;

    initial begin
        reset       = 1'b1;
        istream_val = 1'b0;
        ostream_rdy = 1'b0;
        target      = 4'd0;

        set_vec(0, 4'd11, 4'd8, 4'd12, 4'd10, 4'd11, 4'd11, 0);
        set_vec(1, 4'd0,  4'd8, 4'd4,  4'd2,  4'd1,  4'd0,  0);
        set_vec(2, 4'd15, 4'd8, 4'd12, 4'd14, 4'd15, 4'd15, 0);
        set_vec(3, 4'd6,  4'd8, 4'd4,  4'd6,  4'd7,  4'd6,  3);
        set_vec(4, 4'd3,  4'd8, 4'd4,  4'd2,  4'd3,  4'd3,  1);
        set_vec(5, 4'd9,  4'd8, 4'd12, 4'd10, 4'd9,  4'd9,  0);
        set_vec(6, 4'd5,  4'd8, 4'd4,  4'd6,  4'd5,  4'd5,  2);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_irdy", istream_rdy, 1'b1);
        check("rst_oval", ostream_val, 1'b0);
        check("rst_probe", probe, 4'd0);
        check("rst_msg", ostream_msg, 4'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            ep[0] = vecs[v].p0;
            ep[1] = vecs[v].p1;
            ep[2] = vecs[v].p2;
            ep[3] = vecs[v].p3;
            do_search(vecs[v].target, ep, vecs[v].msg, vecs[v].stall);
        end

        // Back-to-back with istream_val held high: target 3 then 9.
        target      = 4'd3;
        istream_val = 1'b1;
        @(negedge clk);
        ep[0] = 4'd8; ep[1] = 4'd4; ep[2] = 4'd2; ep[3] = 4'd3;
        for (int i = 0; i < 4; i++) begin
            check("b2b_a_probe", probe, ep[i]);
            @(negedge clk);
        end
        check("b2b_a_val", ostream_val, 1'b1);
        @(negedge clk);
        // Held request must not restart anything while DONE waits.
        check("b2b_a_hold_val", ostream_val, 1'b1);
        check("b2b_a_msg", ostream_msg, 4'd3);
        ostream_rdy = 1'b1;
        @(negedge clk);
        ostream_rdy = 1'b0;
        check("b2b_idle_rdy", istream_rdy, 1'b1);
        target = 4'd9;
        @(negedge clk);
        ep[0] = 4'd8; ep[1] = 4'd12; ep[2] = 4'd10; ep[3] = 4'd9;
        for (int i = 0; i < 4; i++) begin
            check("b2b_b_probe", probe, ep[i]);
            @(negedge clk);
        end
        check("b2b_b_val", ostream_val, 1'b1);
        check("b2b_b_msg", ostream_msg, 4'd9);
        istream_val = 1'b0;
        ostream_rdy = 1'b1;
        @(negedge clk);
        ostream_rdy = 1'b0;
        check("b2b_end_rdy", istream_rdy, 1'b1);

        // Asynchronous reset during the 2nd SEARCH cycle (target 5).
        target      = 4'd5;
        istream_val = 1'b1;
        @(negedge clk);
        istream_val = 1'b0;
        check("rst_mid_p0", probe, 4'd8);
        @(posedge clk);
        #2;
        check("rst_mid_p1", probe, 4'd4);
        reset = 1'b1;
        #1;
        check("rst_async_irdy", istream_rdy, 1'b1);
        check("rst_async_oval", ostream_val, 1'b0);
        check("rst_async_probe", probe, 4'd0);
        check("rst_async_msg", ostream_msg, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ep[0] = 4'd8; ep[1] = 4'd4; ep[2] = 4'd6; ep[3] = 4'd5;
        do_search(4'd5, ep, 4'd5, 0);

        // Random searches against a SAR reference model.
        for (int n = 0; n < 50; n++) begin
            logic [3:0] t;
            t = 4'($urandom_range(0, 15));
            r = 4'd0;
            for (int i = 0; i < 4; i++) begin
                p = r | (4'd8 >> i);
                ep[i] = p;
                if (!(p > t)) r = p;
            end
            do_search(t, ep, t, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_search_4b.md
Name: sar_search_4b

Overview:
- Successive-approximation search controller: the initiator side of a greater-than magnitude comparator.
- It drives a probe value into comparator input in0, reads back gt (probe > hidden target), and binary-searches the hidden target value held on in1.
- One search runs per request; the recovered value is returned on a val/rdy output stream.
- Instantiated alongside a GT comparator in lab datapaths (threshold finding, ADC-style conversion).

Parameters:
nbits, 4, width of probe, target and result; must be >= 1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
istream_val  input  1  request to start a search
istream_rdy  output  1  controller can accept a request (high only in IDLE)
probe  output  nbits  value driven to comparator in0
gt  input  1  comparator result, 1 when probe > target (combinational, same cycle)
ostream_val  output  1  result valid (high only in DONE)
ostream_rdy  input  1  consumer accepts result
ostream_msg  output  nbits  recovered target value

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset (async assert, any state): state=IDLE, result=0, idx=0. Outputs: istream_rdy=1, ostream_val=0, probe=0, ostream_msg=0. Reset mid-search abandons the search with no output.
- Internal state: FSM {IDLE, SEARCH, DONE}, result register (nbits), bit index idx (clog2(nbits) bits, min 1).
- IDLE:
  - istream_rdy=1, probe=0.
  - On istream_val=1 at the edge: result<=0, idx<=nbits-1, go SEARCH.
- SEARCH:
  - istream_rdy=0, ostream_val=0.
  - probe = result | (1<<idx), combinational.
  - At the edge: if gt=0, result<=probe (bit kept); if gt=1, result unchanged (bit dropped).
  - If idx==0 go DONE, else idx<=idx-1.
  - Exactly nbits cycles in SEARCH; gt is sampled once per cycle.
- DONE:
  - ostream_val=1, ostream_msg=result, probe=0, istream_rdy=0.
  - On ostream_rdy=1 at the edge: go IDLE. Otherwise hold; ostream_msg stays stable.
- Latency: handshake edge in IDLE, then nbits SEARCH cycles. ostream_val rises in the cycle after the last SEARCH edge, i.e. nbits+1 cycles after request acceptance.
- istream_val is ignored outside IDLE. No queuing, and no request can be lost because rdy=0.
- ostream_msg reads 0 outside DONE except via the result register. Drive ostream_msg=result at all times; it is only meaningful while ostream_val=1.
- Arithmetic:
  - probe never wraps. Bits below idx are always 0 in result, so the OR never overflows nbits.
  - Target=0: every probe gives gt=1, result=0.
  - Target=2^nbits-1: every probe gives gt=0, result=all ones.
- gt is assumed to be driven by a comparator reading probe in the same cycle. No gt latency tolerance.
- Back-to-back operation: request acceptance in IDLE may occur the cycle after the DONE handshake. Throughput is one search per nbits+2 cycles.
- No X on any output after reset; probe is a pure function of state, result and idx.

Test Plan:
- Target 11 (in1=4'b1011, gt from real GT comparator), istream_val pulse -> probes 8,12,10,11 on consecutive SEARCH cycles; ostream_val=1 with msg=11 on cycle 5 after accept.
- Target 0 -> probes 8,4,2,1, all gt=1; msg=0. Target 15 -> probes 8,12,14,15, all gt=0; msg=15.
- Backpressure: target 6, ostream_rdy=0 for 3 cycles -> ostream_val held high, msg=6 stable, istream_rdy=0; assert rdy -> next cycle IDLE, istream_rdy=1.
- istream_val held high throughout: target 3 then target 9 back-to-back -> msgs 3 then 9; second accept the cycle after the first DONE handshake; no extra searches start during SEARCH/DONE.
- Reset asserted asynchronously during the 2nd SEARCH cycle (target 5) -> outputs immediately istream_rdy=1, ostream_val=0, probe=0; new request for target 5 yields msg=5.
- Random: 50 searches, random 4-bit targets, random ostream_rdy stalls -> every msg equals target and the probe sequence matches the SAR reference model.
